// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array command sequencer.
package systolic_pkg;

    // Sequencer top-level states.
    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StFlushW,
        StRunI,
        StFlushI,
        StWaitOut
    } seq_state_t;

    // Encoding of the shared buffer read source select.
    localparam logic BUF_SEL_WEIGHT = 1'b0;
    localparam logic BUF_SEL_INPUT  = 1'b1;

    // Default geometry.
    localparam int unsigned DEF_ROWS     = 8;
    localparam int unsigned DEF_OUT_ROWS = 8;
    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned DEF_CNT_W    = 4;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings: host commands, shared buffer
// read port, systolic array beat interface and output buffer write side.
interface systolic_sequencer_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 4
);
    // Host commands and status.
    logic              load_weight;
    logic              start_inference;
    logic              output_read;
    logic              design_busy;
    logic              data_ready;
    logic              occupancy_err_w;
    logic              occupancy_err_i;
    logic              occupancy_err_o;
    logic              device_busy_err;

    // Shared buffer read port.
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  i_count;
    logic              buf_rd_en;
    logic              buf_sel;
    logic [DATA_W-1:0] buf_rd_data;

    // Systolic array beat interface.
    logic              array_busy;
    logic              array_load;
    logic              array_valid;
    logic              array_start;
    logic [DATA_W-1:0] array_data;

    // Activation return path into the output buffer.
    logic              activations_valid;
    logic              out_full;
    logic              out_wr_en;

    // Sequencer side.
    modport master (
        input  load_weight, start_inference, output_read, w_count, i_count, buf_rd_data,
               array_busy, activations_valid, out_full,
        output buf_rd_en, buf_sel, array_load, array_valid, array_start, array_data,
               out_wr_en, design_busy, data_ready, occupancy_err_w, occupancy_err_i,
               occupancy_err_o, device_busy_err
    );

    // Environment side (buffers, array, host).
    modport slave (
        output load_weight, start_inference, output_read, w_count, i_count, buf_rd_data,
               array_busy, activations_valid, out_full,
        input  buf_rd_en, buf_sel, array_load, array_valid, array_start, array_data,
               out_wr_en, design_busy, data_ready, occupancy_err_w, occupancy_err_i,
               occupancy_err_o, device_busy_err
    );

endinterface

// File: rtl/seq_stream_ctrl.sv
// Streams ROWS words from the shared buffer read port into the array. Used for both the
// weight and input phases; the caller selects the source with sel_i.
module seq_stream_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic              sel_i,
    input  logic              array_busy_i,
    input  logic [DATA_W-1:0] buf_rd_data_i,
    output logic              buf_rd_en_o,
    output logic              buf_sel_o,
    output logic              last_rd_o,
    output logic              beat_valid_o,
    output logic              beat_sel_o,
    output logic              beat_first_o,
    output logic [DATA_W-1:0] beat_data_o
);

    localparam logic [CNT_W-1:0] LastRow = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_sel_q, rd_sel_d;
    logic             rd_first_q, rd_first_d;

    // Read gating, row counting and next state of the one-stage read pipeline.
    always_comb begin
        // array_busy only holds back new reads; a read already issued still lands next cycle.
        buf_rd_en_o = active_i & ~array_busy_i;
        buf_sel_o   = active_i ? sel_i : BUF_SEL_WEIGHT;
        last_rd_o   = buf_rd_en_o && (row_q == LastRow);

        row_d = row_q;
        if (!active_i) begin
            row_d = '0;
        end else if (buf_rd_en_o) begin
            row_d = last_rd_o ? '0 : row_q + CNT_W'(1);
        end

        rd_valid_d = buf_rd_en_o;
        rd_sel_d   = buf_rd_en_o ? sel_i : BUF_SEL_WEIGHT;
        rd_first_d = buf_rd_en_o && (row_q == '0);
    end

    // Row counter and read pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= BUF_SEL_WEIGHT;
            rd_first_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            rd_first_q <= rd_first_d;
        end
    end

    // Beat presented to the array one cycle after its read; the bus idles at zero.
    always_comb begin
        beat_valid_o = rd_valid_q;
        beat_sel_o   = rd_sel_q;
        beat_first_o = rd_valid_q & rd_first_q;
        beat_data_o  = rd_valid_q ? buf_rd_data_i : '0;
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Command sequencer between the host buffer block and the systolic array: streams weights
// or inputs from the shared buffer into the array, then counts activation beats into the
// output buffer and flags results ready. Owns all command-level error pulses.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned OUT_ROWS = DEF_OUT_ROWS,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    systolic_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] RowsFull = CNT_W'(ROWS);
    localparam logic [CNT_W-1:0] LastOut  = CNT_W'(OUT_ROWS - 1);

    seq_state_t       state_q, state_d;
    logic             weights_loaded_q, weights_loaded_d;
    logic             data_ready_q, data_ready_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic             err_w_q, err_w_d;
    logic             err_i_q, err_i_d;
    logic             err_o_q, err_o_d;
    logic             busy_err_q, busy_err_d;

    logic              stream_active;
    logic              stream_sel;
    logic              last_rd;
    logic              beat_valid;
    logic              beat_sel;
    logic              beat_first;
    logic [DATA_W-1:0] beat_data;

    // The same stream controller serves the weight and input phases.
    always_comb begin
        stream_active = (state_q == StLoadW) || (state_q == StRunI);
        stream_sel    = (state_q == StRunI) ? BUF_SEL_INPUT : BUF_SEL_WEIGHT;
    end

    seq_stream_ctrl #(
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_stream (
        .clk           (clk),
        .rst           (rst),
        .active_i      (stream_active),
        .sel_i         (stream_sel),
        .array_busy_i  (bus.array_busy),
        .buf_rd_data_i (bus.buf_rd_data),
        .buf_rd_en_o   (bus.buf_rd_en),
        .buf_sel_o     (bus.buf_sel),
        .last_rd_o     (last_rd),
        .beat_valid_o  (beat_valid),
        .beat_sel_o    (beat_sel),
        .beat_first_o  (beat_first),
        .beat_data_o   (beat_data)
    );

    // Command decode, phase sequencing, activation counting and error pulse generation.
    always_comb begin
        state_d          = state_q;
        weights_loaded_d = weights_loaded_q;
        data_ready_d     = data_ready_q;
        act_cnt_d        = act_cnt_q;
        err_w_d          = 1'b0;
        err_i_d          = 1'b0;
        err_o_d          = 1'b0;
        busy_err_d       = 1'b0;

        if (bus.output_read) begin
            data_ready_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (bus.load_weight) begin
                    if (bus.w_count == RowsFull) begin
                        state_d = StLoadW;
                    end else begin
                        err_w_d = 1'b1;
                    end
                    // load_weight takes priority; a simultaneous start is rejected.
                    busy_err_d = bus.start_inference;
                end else if (bus.start_inference) begin
                    if (weights_loaded_q && (bus.i_count == RowsFull)) begin
                        state_d      = StRunI;
                        data_ready_d = 1'b0;
                    end else begin
                        err_i_d = 1'b1;
                    end
                end
            end
            StLoadW: begin
                if (last_rd) begin
                    state_d = StFlushW;
                end
            end
            StFlushW: begin
                if (beat_valid) begin
                    state_d          = StIdle;
                    weights_loaded_d = 1'b1;
                end
            end
            StRunI: begin
                if (last_rd) begin
                    state_d = StFlushI;
                end
            end
            StFlushI: begin
                if (beat_valid) begin
                    state_d   = StWaitOut;
                    act_cnt_d = '0;
                end
            end
            StWaitOut: begin
                if (bus.activations_valid) begin
                    // A beat dropped on a full output buffer still counts toward completion.
                    act_cnt_d = act_cnt_q + CNT_W'(1);
                    err_o_d   = bus.out_full;
                    if (act_cnt_q == LastOut) begin
                        state_d      = StIdle;
                        data_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q != StIdle) && (bus.load_weight || bus.start_inference)) begin
            busy_err_d = 1'b1;
        end
    end

    // Sequencer state, status flags and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            weights_loaded_q <= 1'b0;
            data_ready_q     <= 1'b0;
            act_cnt_q        <= '0;
            err_w_q          <= 1'b0;
            err_i_q          <= 1'b0;
            err_o_q          <= 1'b0;
            busy_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            weights_loaded_q <= weights_loaded_d;
            data_ready_q     <= data_ready_d;
            act_cnt_q        <= act_cnt_d;
            err_w_q          <= err_w_d;
            err_i_q          <= err_i_d;
            err_o_q          <= err_o_d;
            busy_err_q       <= busy_err_d;
        end
    end

    // Array beat qualification, output buffer write strobe and status outputs.
    always_comb begin
        bus.array_load      = beat_valid && (beat_sel == BUF_SEL_WEIGHT);
        bus.array_valid     = beat_valid && (beat_sel == BUF_SEL_INPUT);
        bus.array_start     = beat_first && (beat_sel == BUF_SEL_INPUT);
        bus.array_data      = beat_data;
        bus.out_wr_en       = (state_q == StWaitOut) && bus.activations_valid && !bus.out_full;
        bus.design_busy     = (state_q != StIdle);
        bus.data_ready      = data_ready_q;
        bus.occupancy_err_w = err_w_q;
        bus.occupancy_err_i = err_i_q;
        bus.occupancy_err_o = err_o_q;
        bus.device_busy_err = busy_err_q;
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: stimulus pushes expected array beats and check
// records into queues; a negedge monitor pops and compares them.
module tb_systolic_sequencer;
    import systolic_pkg::*;

    localparam int unsigned ROWS     = 8;
    localparam int unsigned OUT_ROWS = 8;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned CNT_W    = 4;

    typedef struct {
        logic [63:0] data;
        logic        load;
        logic        start;
        int          cyc;
    } beat_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int tests = 0;
    int fails = 0;
    int n_rd = 0, n_wr = 0, n_ew = 0, n_ei = 0, n_eo = 0, n_eb = 0;

    beat_t beat_q[$];
    chk_t  chk_q[$];

    logic [7:0] gen = 8'h00;
    logic [2:0] wptr, iptr;

    systolic_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    systolic_sequencer #(
        .ROWS     (ROWS),
        .OUT_ROWS (OUT_ROWS),
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mkword(input logic sel, input logic [7:0] g,
                                           input logic [2:0] idx);
        return {(sel ? 8'hB1 : 8'hA0), 40'h0, g, 5'b0, idx};
    endfunction

    // Buffer model: word appears one cycle after the read strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr            <= 3'd0;
            iptr            <= 3'd0;
            bus.buf_rd_data <= '0;
        end else if (bus.buf_rd_en) begin
            if (bus.buf_sel) begin
                bus.buf_rd_data <= mkword(1'b1, gen, iptr);
                iptr            <= iptr + 3'd1;
            end else begin
                bus.buf_rd_data <= mkword(1'b0, gen, wptr);
                wptr            <= wptr + 3'd1;
            end
        end
    end

    // Monitor: drains check records, compares array beats, counts strobes and pulses.
    always @(negedge clk) begin
        chk_t  c;
        beat_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            tests++;
            if (c.act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
            end
        end
        if (!rst) begin
            if (bus.buf_rd_en)       n_rd++;
            if (bus.out_wr_en)       n_wr++;
            if (bus.occupancy_err_w) n_ew++;
            if (bus.occupancy_err_i) n_ei++;
            if (bus.occupancy_err_o) n_eo++;
            if (bus.device_busy_err) n_eb++;
            tests++;
            if (bus.array_load || bus.array_valid) begin
                if (beat_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h at cycle %0d, required none",
                             bus.array_data, cyc);
                end else begin
                    e = beat_q.pop_front();
                    if ({bus.array_load, bus.array_valid, bus.array_start, bus.array_data} !==
                            {e.load, ~e.load, e.start, e.data} ||
                        (e.cyc >= 0 && e.cyc != cyc)) begin
                        fails++;
                        $display("FAIL beat: got ld=%b vl=%b st=%b d=%0h cyc=%0d, required ld=%b st=%b d=%0h cyc=%0d",
                                 bus.array_load, bus.array_valid, bus.array_start,
                                 bus.array_data, cyc, e.load, e.start, e.data, e.cyc);
                    end
                end
            end else if (bus.array_start || bus.array_data != '0) begin
                fails++;
                $display("FAIL idle_bus: got start=%b data=%0h, required 0 0",
                         bus.array_start, bus.array_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_beats(input logic sel, input logic [7:0] g, input int t0);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.data  = mkword(sel, g, 3'(k));
            b.load  = ~sel;
            b.start = sel && (k == 0);
            b.cyc   = (t0 < 0) ? -1 : t0 + 2 + k;
            beat_q.push_back(b);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (beat_q.size() != 0 && k < 64) begin
            tick();
            k++;
        end
        chk(name, 64'(beat_q.size()), 64'd0);
    endtask

    task automatic feed_acts(input logic [7:0] full_mask);
        for (int i = 0; i < 8; i++) begin
            bus.activations_valid = 1'b1;
            bus.out_full          = full_mask[i];
            tick();
        end
        bus.activations_valid = 1'b0;
        bus.out_full          = 1'b0;
    endtask

    function automatic logic [63:0] ctl_vec();
        return {52'h0, bus.buf_rd_en, bus.buf_sel, bus.array_load, bus.array_valid,
                bus.array_start, bus.out_wr_en, bus.design_busy, bus.data_ready,
                bus.occupancy_err_w, bus.occupancy_err_i, bus.occupancy_err_o,
                bus.device_busy_err};
    endfunction

    initial begin
        int t, s_rd, s_wr, s_ew, s_ei, s_eo, s_eb;
        bus.load_weight       = 1'b0;
        bus.start_inference   = 1'b0;
        bus.output_read       = 1'b0;
        bus.w_count           = '0;
        bus.i_count           = '0;
        bus.array_busy        = 1'b0;
        bus.activations_valid = 1'b0;
        bus.out_full          = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("reset_ctl", ctl_vec(), 64'd0);
        chk("reset_data", bus.array_data, 64'd0);
        rst = 1'b0;
        tick();

        // Short weight buffer, then inference with no weights loaded.
        s_rd = n_rd; s_ew = n_ew; s_ei = n_ei;
        bus.w_count = 4'd5;
        bus.load_weight = 1'b1;
        tick();
        bus.load_weight = 1'b0;
        chk("short_w_busy", 64'(bus.design_busy), 64'd0);
        repeat (2) tick();
        chk("short_w_err", 64'(n_ew - s_ew), 64'd1);
        chk("short_w_rd", 64'(n_rd - s_rd), 64'd0);
        bus.i_count = 4'd8;
        bus.start_inference = 1'b1;
        tick();
        bus.start_inference = 1'b0;
        repeat (2) tick();
        chk("no_weights_err", 64'(n_ei - s_ei), 64'd1);
        chk("no_weights_busy", 64'(bus.design_busy), 64'd0);

        // Activations while idle are ignored.
        s_wr = n_wr; s_eo = n_eo;
        bus.activations_valid = 1'b1;
        bus.out_full = 1'b1;
        repeat (2) tick();
        bus.activations_valid = 1'b0;
        bus.out_full = 1'b0;
        tick();
        chk("idle_act_wr", 64'(n_wr - s_wr), 64'd0);
        chk("idle_act_err", 64'(n_eo - s_eo), 64'd0);

        // Weight load with exact beat timing T+2..T+9, idle again at T+10.
        gen = 8'h01;
        bus.w_count = 4'd8;
        t = cyc;
        push_beats(1'b0, gen, t);
        bus.load_weight = 1'b1;
        tick();
        bus.load_weight = 1'b0;
        while (cyc < t + 9) tick();
        chk("w_busy_t9", 64'(bus.design_busy), 64'd1);
        tick();
        chk("w_busy_t10", 64'(bus.design_busy), 64'd0);
        chk("w_drained", 64'(beat_q.size()), 64'd0);

        // Inference with a 3-cycle array stall and a rejected command mid-stream.
        gen = 8'h02;
        s_wr = n_wr; s_eo = n_eo; s_eb = n_eb;
        push_beats(1'b1, gen, -1);
        bus.start_inference = 1'b1;
        tick();
        bus.start_inference = 1'b0;
        tick();
        bus.array_busy = 1'b1;
        bus.load_weight = 1'b1;
        tick();
        bus.load_weight = 1'b0;
        repeat (2) tick();
        bus.array_busy = 1'b0;
        drain("run1_drain");
        feed_acts(8'h00);
        chk("run1_ready", 64'(bus.data_ready), 64'd1);
        chk("run1_idle", 64'(bus.design_busy), 64'd0);
        tick();
        chk("run1_wr", 64'(n_wr - s_wr), 64'd8);
        chk("run1_err_o", 64'(n_eo - s_eo), 64'd0);
        chk("run1_busy_err", 64'(n_eb - s_eb), 64'd1);

        // Second inference clears data_ready; two beats dropped on a full output buffer.
        gen = 8'h03;
        s_wr = n_wr; s_eo = n_eo;
        push_beats(1'b1, gen, -1);
        bus.start_inference = 1'b1;
        tick();
        bus.start_inference = 1'b0;
        chk("run2_ready_clr", 64'(bus.data_ready), 64'd0);
        drain("run2_drain");
        feed_acts(8'b0010_0100);
        chk("run2_ready", 64'(bus.data_ready), 64'd1);
        chk("run2_idle", 64'(bus.design_busy), 64'd0);
        tick();
        chk("run2_wr", 64'(n_wr - s_wr), 64'd6);
        chk("run2_err_o", 64'(n_eo - s_eo), 64'd2);
        bus.output_read = 1'b1;
        tick();
        bus.output_read = 1'b0;
        chk("read_clr", 64'(bus.data_ready), 64'd0);

        // Both commands at once: load wins, start rejected; then reset mid-load.
        gen = 8'h04;
        s_eb = n_eb;
        t = cyc;
        push_beats(1'b0, gen, t);
        bus.load_weight = 1'b1;
        bus.start_inference = 1'b1;
        tick();
        bus.load_weight = 1'b0;
        bus.start_inference = 1'b0;
        chk("both_busy", 64'(bus.design_busy), 64'd1);
        repeat (3) tick();
        chk("both_busy_err", 64'(n_eb - s_eb), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", ctl_vec(), 64'd0);
        chk("midrst_data", bus.array_data, 64'd0);
        beat_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        s_ei = n_ei;
        bus.start_inference = 1'b1;
        tick();
        bus.start_inference = 1'b0;
        repeat (2) tick();
        chk("post_rst_err_i", 64'(n_ei - s_ei), 64'd1);
        chk("post_rst_idle", 64'(bus.design_busy), 64'd0);

        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
